robot_leg_motion_seq: RTL and testbench

ROBOT_LEG_MOTION_SEQ -- requirements
Module: robot_leg_motion_seq

---
 rtl/robot_motion_pkg.sv | 22 ++
 rtl/robot_speed_ramp.sv | 41 ++++
 rtl/robot_leg_motion_seq.sv | 252 +++++++++++++++++++++++++
 tb/tb_robot_leg_motion_seq.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/robot_motion_pkg.sv
// Shared definitions for the robot leg motion sequencer.
//   SPEED_MAX   : upper bound for any speed value, in percent.
//   state_t     : sequencer state encoding, also exported on the debug port.
//   clamp_speed : limits a commanded speed to SPEED_MAX.
package robot_motion_pkg;

    localparam logic [7:0] SPEED_MAX = 8'd100;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_RAMP      = 3'd1,
        ST_RUN       = 3'd2,
        ST_RAMP_DOWN = 3'd3,
        ST_DEADTIME  = 3'd4,
        ST_ESTOP     = 3'd5
    } state_t;

    function automatic logic [7:0] clamp_speed(input logic [7:0] value);
        return (value > SPEED_MAX) ? SPEED_MAX : value;
    endfunction

endpackage

// File: rtl/robot_speed_ramp.sv
// One speed channel: holds the present speed and steps it by one toward
// its target on every enabled tick.
//   clk, reset_p : clock and asynchronous active-high reset
//   clear        : synchronous force of the speed to zero
//   tick         : ramp timebase pulse
//   step_en      : ramping allowed in the current sequencer state
//   target       : speed being approached (already limited to SPEED_MAX)
//   speed        : present speed
//   at_target    : speed equals target
module robot_speed_ramp
    import robot_motion_pkg::*;
(
    input  logic       clk,
    input  logic       reset_p,
    input  logic       clear,
    input  logic       tick,
    input  logic       step_en,
    input  logic [7:0] target,
    output logic [7:0] speed,
    output logic       at_target
);

    assign at_target = (speed == target);

    // Decrement only happens when speed > target, so speed is nonzero and
    // cannot wrap; the SPEED_MAX guard keeps a bad target from overshooting.
    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) begin
            speed <= '0;
        end else if (clear) begin
            speed <= '0;
        end else if (tick && step_en) begin
            if ((speed < target) && (speed < SPEED_MAX)) begin
                speed <= speed + 8'd1;
            end else if (speed > target) begin
                speed <= speed - 8'd1;
            end
        end
    end

endmodule

// File: rtl/robot_leg_motion_seq.sv
// Motion sequencer for a two-motor robot leg. Accepts speed/direction
// commands, ramps the motor speeds, inserts a zero-speed dwell before any
// direction reversal, stops automatically when commands go silent and
// honours an emergency stop.
//   clk, reset_p            : clock and asynchronous active-high reset
//   cmd_valid / cmd_ready   : command handshake; a command transfers on a
//                             rising clk edge where both are high. cmd_valid
//                             may be held; cmd_ready is low in the busy
//                             reversal states and while estop is high.
//   cmd_left, cmd_right     : target speeds in percent (clamped to 100)
//   cmd_dir                 : target H-bridge direction pattern
//   estop                   : level-sensitive emergency stop
//   out_left_speed/right    : speeds to the motor PWM block
//   out_direction           : motor direction pattern
//   busy                    : high outside IDLE and RUN
//   fault_wdt               : sticky watchdog-expiry flag
//   dbg_state               : present sequencer state
module robot_leg_motion_seq
    import robot_motion_pkg::*;
#(
    parameter int unsigned RAMP_DIV     = 100000,
    parameter int unsigned DEADTIME_CYC = 5000000,
    parameter int unsigned WDT_CYC      = 50000000
) (
    input  logic       clk,
    input  logic       reset_p,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [7:0] cmd_left,
    input  logic [7:0] cmd_right,
    input  logic [3:0] cmd_dir,
    input  logic       estop,
    output logic [7:0] out_left_speed,
    output logic [7:0] out_right_speed,
    output logic [3:0] out_direction,
    output logic       busy,
    output logic       fault_wdt,
    output state_t     dbg_state
);

    state_t      state;
    state_t      state_next;
    logic [31:0] tick_cnt;
    logic [31:0] wdt_cnt;
    logic [31:0] dead_cnt;
    logic [7:0]  tgt_left;
    logic [7:0]  tgt_right;
    logic [7:0]  pend_left;
    logic [7:0]  pend_right;
    logic [3:0]  pend_dir;
    logic [7:0]  ramp_tgt_left;
    logic [7:0]  ramp_tgt_right;
    logic        tick;
    logic        step_en;
    logic        at_left;
    logic        at_right;
    logic        speeds_zero;
    logic        dir_same;
    logic        accept;
    logic        wdt_run;
    logic        wdt_expire;
    logic        dead_done;

    // Free-running ramp timebase, independent of state.
    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) begin
            tick_cnt <= '0;
        end else if (tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + 32'd1;
        end
    end
    assign tick = (tick_cnt == RAMP_DIV - 1);

    assign accept      = cmd_valid && cmd_ready;
    assign speeds_zero = (out_left_speed == 8'd0) && (out_right_speed == 8'd0);
    // With the motors stopped a direction change needs no dwell.
    assign dir_same    = (cmd_dir == out_direction) || speeds_zero;
    assign wdt_run     = (state == ST_RAMP) || (state == ST_RUN);
    // A same-cycle accept reloads the watchdog instead of tripping it.
    assign wdt_expire  = wdt_run && (wdt_cnt == WDT_CYC - 1) && !accept;
    assign dead_done   = (state == ST_DEADTIME) && (dead_cnt == DEADTIME_CYC - 1);
    assign dbg_state   = state;

    // State register
    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; estop overrides everything.
    always_comb begin
        state_next = state;
        if (estop) begin
            state_next = ST_ESTOP;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) state_next = dir_same ? ST_RAMP : ST_RAMP_DOWN;
                end
                ST_RAMP: begin
                    if (accept) begin
                        state_next = dir_same ? ST_RAMP : ST_RAMP_DOWN;
                    end else if (wdt_expire) begin
                        state_next = ST_RAMP;
                    end else if (at_left && at_right) begin
                        state_next = ((tgt_left == 8'd0) && (tgt_right == 8'd0)) ? ST_IDLE : ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (accept) begin
                        state_next = dir_same ? ST_RAMP : ST_RAMP_DOWN;
                    end else if (wdt_expire) begin
                        state_next = ST_RAMP;
                    end
                end
                ST_RAMP_DOWN: begin
                    if (speeds_zero) state_next = ST_DEADTIME;
                end
                ST_DEADTIME: begin
                    if (dead_done) state_next = ST_RAMP;
                end
                ST_ESTOP: begin
                    state_next = ST_IDLE;
                end
                default: begin
                    state_next = ST_IDLE;
                end
            endcase
        end
    end

    // Output / control decode
    always_comb begin
        cmd_ready      = 1'b0;
        busy           = 1'b1;
        step_en        = 1'b0;
        ramp_tgt_left  = tgt_left;
        ramp_tgt_right = tgt_right;
        case (state)
            ST_IDLE: begin
                cmd_ready = !estop;
                busy      = 1'b0;
            end
            ST_RAMP: begin
                cmd_ready = !estop;
                step_en   = 1'b1;
            end
            ST_RUN: begin
                cmd_ready = !estop;
                busy      = 1'b0;
            end
            ST_RAMP_DOWN: begin
                step_en        = 1'b1;
                ramp_tgt_left  = 8'd0;
                ramp_tgt_right = 8'd0;
            end
            default: begin
            end
        endcase
    end

    // Targets, pending command, direction, watchdog and dwell counter.
    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) begin
            tgt_left      <= '0;
            tgt_right     <= '0;
            pend_left     <= '0;
            pend_right    <= '0;
            pend_dir      <= '0;
            out_direction <= '0;
            fault_wdt     <= 1'b0;
            wdt_cnt       <= '0;
            dead_cnt      <= '0;
        end else if (estop) begin
            tgt_left      <= '0;
            tgt_right     <= '0;
            pend_left     <= '0;
            pend_right    <= '0;
            pend_dir      <= '0;
            out_direction <= '0;
            wdt_cnt       <= '0;
            dead_cnt      <= '0;
        end else begin
            if (accept) begin
                fault_wdt <= 1'b0;
                wdt_cnt   <= '0;
                if (dir_same) begin
                    out_direction <= cmd_dir;
                    tgt_left      <= clamp_speed(cmd_left);
                    tgt_right     <= clamp_speed(cmd_right);
                end else begin
                    pend_dir   <= cmd_dir;
                    pend_left  <= clamp_speed(cmd_left);
                    pend_right <= clamp_speed(cmd_right);
                end
            end else if (wdt_expire) begin
                fault_wdt <= 1'b1;
                tgt_left  <= '0;
                tgt_right <= '0;
                wdt_cnt   <= '0;
            end else if (wdt_run) begin
                wdt_cnt <= wdt_cnt + 32'd1;
            end

            // No command can be accepted in DEADTIME, so these loads never
            // collide with the accept path above.
            if (state == ST_DEADTIME) begin
                if (dead_done) begin
                    out_direction <= pend_dir;
                    tgt_left      <= pend_left;
                    tgt_right     <= pend_right;
                    pend_dir      <= '0;
                    pend_left     <= '0;
                    pend_right    <= '0;
                    dead_cnt      <= '0;
                end else begin
                    dead_cnt <= dead_cnt + 32'd1;
                end
            end else begin
                dead_cnt <= '0;
            end
        end
    end

    robot_speed_ramp u_ramp_left (
        .clk       (clk),
        .reset_p   (reset_p),
        .clear     (estop),
        .tick      (tick),
        .step_en   (step_en),
        .target    (ramp_tgt_left),
        .speed     (out_left_speed),
        .at_target (at_left)
    );

    robot_speed_ramp u_ramp_right (
        .clk       (clk),
        .reset_p   (reset_p),
        .clear     (estop),
        .tick      (tick),
        .step_en   (step_en),
        .target    (ramp_tgt_right),
        .speed     (out_right_speed),
        .at_target (at_right)
    );

endmodule

// File: tb/tb_robot_leg_motion_seq.sv
// Directed bench for robot_leg_motion_seq with short timing parameters.
module tb_robot_leg_motion_seq;
    import robot_motion_pkg::*;

    localparam int unsigned RAMP_DIV     = 4;
    localparam int unsigned DEADTIME_CYC = 10;
    localparam int unsigned WDT_CYC      = 200;

    logic       clk = 1'b0;
    logic       reset_p;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [7:0] cmd_left;
    logic [7:0] cmd_right;
    logic [3:0] cmd_dir;
    logic       estop;
    logic [7:0] out_left_speed;
    logic [7:0] out_right_speed;
    logic [3:0] out_direction;
    logic       busy;
    logic       fault_wdt;
    state_t     dbg_state;

    int n_cmp = 0;
    int n_err = 0;

    robot_leg_motion_seq #(
        .RAMP_DIV     (RAMP_DIV),
        .DEADTIME_CYC (DEADTIME_CYC),
        .WDT_CYC      (WDT_CYC)
    ) dut (
        .clk             (clk),
        .reset_p         (reset_p),
        .cmd_valid       (cmd_valid),
        .cmd_ready       (cmd_ready),
        .cmd_left        (cmd_left),
        .cmd_right       (cmd_right),
        .cmd_dir         (cmd_dir),
        .estop           (estop),
        .out_left_speed  (out_left_speed),
        .out_right_speed (out_right_speed),
        .out_direction   (out_direction),
        .busy            (busy),
        .fault_wdt       (fault_wdt),
        .dbg_state       (dbg_state)
    );

    // Clock
    always #5 clk = ~clk;

    // Global time limit
    initial begin
        #200000;
        $display("FAIL time_limit: simulation did not finish, observed timeout expected completion");
        $fatal(1, "time limit");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance n rising edges, then settle 1 time unit past the edge.
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Present a command for exactly one edge.
    task automatic send(input logic [7:0] l, input logic [7:0] r, input logic [3:0] d);
        cmd_valid = 1'b1;
        cmd_left  = l;
        cmd_right = r;
        cmd_dir   = d;
        step(1);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_state(input state_t s, input int bound);
        int i;
        i = 0;
        while (dbg_state !== s && i < bound) begin
            step(1);
            i++;
        end
    endtask

    task automatic wait_left(input logic [7:0] v, input int bound);
        int i;
        i = 0;
        while (out_left_speed !== v && i < bound) begin
            step(1);
            i++;
        end
    endtask

    task automatic wait_zero(input int bound);
        int i;
        i = 0;
        while (!(out_left_speed === 8'd0 && out_right_speed === 8'd0) && i < bound) begin
            step(1);
            i++;
        end
    endtask

    initial begin
        int dwell;
        int cyc;
        logic over;

        reset_p   = 1'b1;
        cmd_valid = 1'b0;
        cmd_left  = '0;
        cmd_right = '0;
        cmd_dir   = '0;
        estop     = 1'b0;
        step(2);

        // Reset values
        check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
        check("rst_left", 32'(out_left_speed), 0);
        check("rst_right", 32'(out_right_speed), 0);
        check("rst_dir", 32'(out_direction), 0);
        check("rst_fault", 32'(fault_wdt), 0);
        check("rst_ready", 32'(cmd_ready), 1);
        check("rst_busy", 32'(busy), 0);
        reset_p = 1'b0;
        step(1);

        // Ramp-up 5/3, dir 1010
        send(8'd5, 8'd3, 4'b1010);
        check("up_dir", 32'(out_direction), 32'(4'b1010));
        check("up_state", 32'(dbg_state), 32'(ST_RAMP));
        check("up_busy", 32'(busy), 1);
        wait_left(8'd1, 8);
        check("up_l1", 32'(out_left_speed), 1);
        check("up_r1", 32'(out_right_speed), 1);
        step(2);
        check("up_l1_hold", 32'(out_left_speed), 1);
        step(2);
        check("up_l2", 32'(out_left_speed), 2);
        check("up_r2", 32'(out_right_speed), 2);
        step(4);
        check("up_l3", 32'(out_left_speed), 3);
        check("up_r3", 32'(out_right_speed), 3);
        step(4);
        check("up_l4", 32'(out_left_speed), 4);
        check("up_r3_hold", 32'(out_right_speed), 3);
        step(4);
        check("up_l5", 32'(out_left_speed), 5);
        check("up_r5_state", 32'(dbg_state), 32'(ST_RAMP));
        step(1);
        check("up_run", 32'(dbg_state), 32'(ST_RUN));
        check("up_run_busy", 32'(busy), 0);
        check("up_run_r", 32'(out_right_speed), 3);

        // Reversal to 0101 at 2/2
        send(8'd2, 8'd2, 4'b0101);
        check("rev_state", 32'(dbg_state), 32'(ST_RAMP_DOWN));
        check("rev_ready", 32'(cmd_ready), 0);
        check("rev_busy", 32'(busy), 1);
        check("rev_dir_old", 32'(out_direction), 32'(4'b1010));
        wait_zero(40);
        check("rev_zero_l", 32'(out_left_speed), 0);
        check("rev_zero_r", 32'(out_right_speed), 0);
        step(1);
        check("rev_dead", 32'(dbg_state), 32'(ST_DEADTIME));
        check("rev_dead_dir", 32'(out_direction), 32'(4'b1010));
        dwell = 0;
        while (dbg_state === ST_DEADTIME && dwell < 50) begin
            dwell++;
            step(1);
        end
        check("rev_dwell", 32'(dwell), 10);
        check("rev_new_dir", 32'(out_direction), 32'(4'b0101));
        check("rev_ramp", 32'(dbg_state), 32'(ST_RAMP));
        wait_state(ST_RUN, 30);
        check("rev_run", 32'(dbg_state), 32'(ST_RUN));
        check("rev_l2", 32'(out_left_speed), 2);
        check("rev_r2", 32'(out_right_speed), 2);

        // Watchdog: refresh, then 200 silent cycles
        send(8'd2, 8'd2, 4'b0101);
        step(199);
        check("wdt_pre", 32'(fault_wdt), 0);
        check("wdt_pre_state", 32'(dbg_state), 32'(ST_RUN));
        step(1);
        check("wdt_fault", 32'(fault_wdt), 1);
        check("wdt_ramp", 32'(dbg_state), 32'(ST_RAMP));
        wait_state(ST_IDLE, 30);
        check("wdt_idle", 32'(dbg_state), 32'(ST_IDLE));
        check("wdt_l0", 32'(out_left_speed), 0);
        check("wdt_r0", 32'(out_right_speed), 0);
        check("wdt_sticky", 32'(fault_wdt), 1);

        // Clamp: 200 -> 100; the accept also clears the fault
        send(8'd200, 8'd100, 4'b0101);
        check("clamp_fault_clr", 32'(fault_wdt), 0);
        check("clamp_state", 32'(dbg_state), 32'(ST_RAMP));
        over = 1'b0;
        cyc  = 0;
        while (dbg_state !== ST_RUN && cyc < 700) begin
            if (cyc % 100 == 99) send(8'd200, 8'd100, 4'b0101);
            else step(1);
            cyc++;
            if (out_left_speed > 8'd100 || out_right_speed > 8'd100) over = 1'b1;
        end
        check("clamp_run", 32'(dbg_state), 32'(ST_RUN));
        check("clamp_l", 32'(out_left_speed), 100);
        check("clamp_r", 32'(out_right_speed), 100);
        check("clamp_over", 32'(over), 0);
        step(8);
        check("clamp_hold_l", 32'(out_left_speed), 100);
        check("clamp_hold_r", 32'(out_right_speed), 100);

        // E-stop mid-RAMP with a simultaneous command
        send(8'd50, 8'd50, 4'b0101);
        step(6);
        check("es_pre", 32'(dbg_state), 32'(ST_RAMP));
        cmd_valid = 1'b1;
        cmd_left  = 8'd10;
        cmd_right = 8'd10;
        cmd_dir   = 4'b1111;
        estop     = 1'b1;
        step(1);
        cmd_valid = 1'b0;
        check("es_state", 32'(dbg_state), 32'(ST_ESTOP));
        check("es_l", 32'(out_left_speed), 0);
        check("es_r", 32'(out_right_speed), 0);
        check("es_dir", 32'(out_direction), 0);
        check("es_busy", 32'(busy), 1);
        step(2);
        check("es_hold", 32'(dbg_state), 32'(ST_ESTOP));
        estop = 1'b0;
        step(1);
        check("es_idle", 32'(dbg_state), 32'(ST_IDLE));
        check("es_idle_busy", 32'(busy), 0);
        check("es_idle_ready", 32'(cmd_ready), 1);
        step(12);
        check("es_after_l", 32'(out_left_speed), 0);
        check("es_after_dir", 32'(out_direction), 0);
        check("es_after_state", 32'(dbg_state), 32'(ST_IDLE));

        // Reset during DEADTIME
        send(8'd4, 8'd4, 4'b1100);
        check("rd_dir", 32'(out_direction), 32'(4'b1100));
        wait_left(8'd2, 12);
        check("rd_l2", 32'(out_left_speed), 2);
        send(8'd1, 8'd1, 4'b0011);
        check("rd_down", 32'(dbg_state), 32'(ST_RAMP_DOWN));
        wait_state(ST_DEADTIME, 40);
        check("rd_dead", 32'(dbg_state), 32'(ST_DEADTIME));
        step(3);
        reset_p = 1'b1;
        #1;
        check("rd_rst_state", 32'(dbg_state), 32'(ST_IDLE));
        check("rd_rst_l", 32'(out_left_speed), 0);
        check("rd_rst_r", 32'(out_right_speed), 0);
        check("rd_rst_dir", 32'(out_direction), 0);
        check("rd_rst_ready", 32'(cmd_ready), 1);
        check("rd_rst_busy", 32'(busy), 0);
        check("rd_rst_fault", 32'(fault_wdt), 0);
        step(2);
        reset_p = 1'b0;
        step(30);
        check("rd_after_dir", 32'(out_direction), 0);
        check("rd_after_state", 32'(dbg_state), 32'(ST_IDLE));
        check("rd_after_l", 32'(out_left_speed), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
